// File: rtl/fp_operand_prep.sv
// fp_operand_prep
// Registered pre-alignment stage that sits in front of the FP add/sub datapath.
// It takes two IEEE-754 single-precision operands and an add/subtract select
// over a valid/ready handshake. It unpacks both operands and orders them by
// magnitude. It also computes the clamped alignment shift and resolves the
// NaN/Inf cases. The result is one registered operand set for the
// swap/shift/add stages that follow.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  upstream handshake for a, b, operation_select
//   a, b               IEEE-754 operands
//   operation_select   0 = a+b, 1 = a-b
//   out_valid/out_ready downstream handshake for every out_* signal
//   out_sign_l/_s      effective signs of the larger / smaller operand
//   out_exp_l          biased exponent of the larger operand (denormal -> 1)
//   out_mant_l/_s      mantissas with the hidden bit restored
//   out_shift          right shift for out_mant_s, saturated at MANT_BITS+3
//   out_eff_sub        operation is an effective subtraction
//   out_a_greater      |a| >= |b|
//   out_special        out_special_res is already the final result
//   out_special_res    final result for NaN/Inf cases
//   out_invalid        IEEE invalid-operation flag
module fp_operand_prep #(
   parameter int WIDTH     = 32,
   parameter int EXP_BITS  = 8,
   parameter int MANT_BITS = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 operation_select,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign_l,
   output logic                 out_sign_s,
   output logic [EXP_BITS-1:0]  out_exp_l,
   output logic [MANT_BITS:0]   out_mant_l,
   output logic [MANT_BITS:0]   out_mant_s,
   output logic [4:0]           out_shift,
   output logic                 out_eff_sub,
   output logic                 out_a_greater,
   output logic                 out_special,
   output logic [WIDTH-1:0]     out_special_res,
   output logic                 out_invalid
);

   localparam logic [EXP_BITS-1:0] EXP_ONES  = '1;
   localparam logic [EXP_BITS-1:0] SHIFT_SAT = EXP_BITS'(MANT_BITS + 3);
   localparam logic [WIDTH-1:0]    QNAN      =
      {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

   logic                 sign_a;
   logic                 sb_eff;
   logic [EXP_BITS-1:0]  exp_a;
   logic [EXP_BITS-1:0]  exp_b;
   logic [EXP_BITS-1:0]  eff_exp_a;
   logic [EXP_BITS-1:0]  eff_exp_b;
   logic [EXP_BITS-1:0]  exp_diff;
   logic [MANT_BITS-1:0] man_a;
   logic [MANT_BITS-1:0] man_b;
   logic [MANT_BITS:0]   full_a;
   logic [MANT_BITS:0]   full_b;
   logic                 nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
   logic                 a_greater_c;
   logic                 eff_sub_c;
   logic                 sign_l_c, sign_s_c;
   logic [EXP_BITS-1:0]  exp_l_c;
   logic [MANT_BITS:0]   mant_l_c, mant_s_c;
   logic [4:0]           shift_c;
   logic                 special_c;
   logic [WIDTH-1:0]     special_res_c;
   logic                 invalid_c;
   logic                 capture;

   // A new set can enter whenever the output register is empty or is being
   // drained in this same cycle, which gives one operand set per cycle.
   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready;

   // Unpack both operands and restore the hidden bit. For b, fold the
   // subtract select into its sign so everything downstream sees an addition.
   // Denormals and zeros use an effective exponent of 1, so a denormal lines
   // up correctly against the smallest normal number.
   always_comb begin
      sign_a    = a[WIDTH-1];
      sb_eff    = b[WIDTH-1] ^ operation_select;
      exp_a     = a[WIDTH-2 -: EXP_BITS];
      exp_b     = b[WIDTH-2 -: EXP_BITS];
      man_a     = a[MANT_BITS-1:0];
      man_b     = b[MANT_BITS-1:0];
      full_a    = {(exp_a != '0), man_a};
      full_b    = {(exp_b != '0), man_b};
      eff_exp_a = (exp_a == '0) ? EXP_BITS'(1) : exp_a;
      eff_exp_b = (exp_b == '0) ? EXP_BITS'(1) : exp_b;
      eff_sub_c = sign_a ^ sb_eff;
      nan_a     = (exp_a == EXP_ONES) && (man_a != '0);
      nan_b     = (exp_b == EXP_ONES) && (man_b != '0);
      snan_a    = nan_a && !man_a[MANT_BITS-1];
      snan_b    = nan_b && !man_b[MANT_BITS-1];
      inf_a     = (exp_a == EXP_ONES) && (man_a == '0);
      inf_b     = (exp_b == EXP_ONES) && (man_b == '0);
   end

   // Order the operands by magnitude. The raw {exp, man} fields compare the
   // same way as the magnitudes, and a tie keeps a on the large side. Because
   // the ordering uses raw exponents, eff_l >= eff_s always holds, so the
   // difference cannot wrap. Any gap past MANT_BITS+3 shifts everything into
   // sticky territory and is clamped there.
   always_comb begin
      a_greater_c = {exp_a, man_a} >= {exp_b, man_b};
      sign_l_c    = a_greater_c ? sign_a    : sb_eff;
      sign_s_c    = a_greater_c ? sb_eff    : sign_a;
      exp_l_c     = a_greater_c ? eff_exp_a : eff_exp_b;
      mant_l_c    = a_greater_c ? full_a    : full_b;
      mant_s_c    = a_greater_c ? full_b    : full_a;
      exp_diff    = a_greater_c ? (eff_exp_a - eff_exp_b) : (eff_exp_b - eff_exp_a);
      shift_c     = (exp_diff > SHIFT_SAT) ? SHIFT_SAT[4:0] : exp_diff[4:0];
   end

   // Special-case resolution, highest priority first. Only a signalling NaN
   // raises invalid among the NaN inputs. Inf - Inf yields the default qNaN
   // and is invalid. Any other infinity is returned with its effective sign.
   // When both operands are Inf and there is no effective subtraction, their
   // signs agree, so taking a's sign is correct.
   always_comb begin
      special_c     = 1'b0;
      special_res_c = '0;
      invalid_c     = 1'b0;
      if (nan_a || nan_b) begin
         special_c     = 1'b1;
         special_res_c = QNAN;
         invalid_c     = snan_a || snan_b;
      end else if (inf_a && inf_b && eff_sub_c) begin
         special_c     = 1'b1;
         special_res_c = QNAN;
         invalid_c     = 1'b1;
      end else if (inf_a) begin
         special_c     = 1'b1;
         special_res_c = {sign_a, EXP_ONES, {MANT_BITS{1'b0}}};
      end else if (inf_b) begin
         special_c     = 1'b1;
         special_res_c = {sb_eff, EXP_ONES, {MANT_BITS{1'b0}}};
      end
   end

   // Output register. Data is loaded only on capture, so it stays stable
   // under backpressure. Valid clears after a transfer unless a replacement
   // is captured in the same cycle. Reset drops any held set.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_sign_l      <= 1'b0;
         out_sign_s      <= 1'b0;
         out_exp_l       <= '0;
         out_mant_l      <= '0;
         out_mant_s      <= '0;
         out_shift       <= '0;
         out_eff_sub     <= 1'b0;
         out_a_greater   <= 1'b0;
         out_special     <= 1'b0;
         out_special_res <= '0;
         out_invalid     <= 1'b0;
      end else if (capture) begin
         out_valid       <= 1'b1;
         out_sign_l      <= sign_l_c;
         out_sign_s      <= sign_s_c;
         out_exp_l       <= exp_l_c;
         out_mant_l      <= mant_l_c;
         out_mant_s      <= mant_s_c;
         out_shift       <= shift_c;
         out_eff_sub     <= eff_sub_c;
         out_a_greater   <= a_greater_c;
         out_special     <= special_c;
         out_special_res <= special_res_c;
         out_invalid     <= invalid_c;
      end else if (out_ready) begin
         out_valid       <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp_operand_prep.sv
// tb_fp_operand_prep
// Directed bench for fp_operand_prep. A table of hand-computed vectors is
// pushed through one at a time with out_ready high. After that come hand-written
// sequences for backpressure ordering and for reset while a set is held.
module tb_fp_operand_prep;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        op;
      logic        sign_l;
      logic        sign_s;
      logic [7:0]  exp_l;
      logic [23:0] mant_l;
      logic [23:0] mant_s;
      logic [4:0]  shift;
      logic        eff_sub;
      logic        a_greater;
      logic        special;
      logic [31:0] res;
      logic        invalid;
   } vec_t;

   localparam int NVEC = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        operation_select = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_sign_l;
   logic        out_sign_s;
   logic [7:0]  out_exp_l;
   logic [23:0] out_mant_l;
   logic [23:0] out_mant_s;
   logic [4:0]  out_shift;
   logic        out_eff_sub;
   logic        out_a_greater;
   logic        out_special;
   logic [31:0] out_special_res;
   logic        out_invalid;

   int   total = 0;
   int   bad   = 0;
   vec_t vecs[NVEC];

   fp_operand_prep dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .a                (a),
      .b                (b),
      .operation_select (operation_select),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_sign_l       (out_sign_l),
      .out_sign_s       (out_sign_s),
      .out_exp_l        (out_exp_l),
      .out_mant_l       (out_mant_l),
      .out_mant_s       (out_mant_s),
      .out_shift        (out_shift),
      .out_eff_sub      (out_eff_sub),
      .out_a_greater    (out_a_greater),
      .out_special      (out_special),
      .out_special_res  (out_special_res),
      .out_invalid      (out_invalid)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Compare one observed value against its expectation and log any miss.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Present one operand set at the falling edge, let it be captured at the
   // rising edge, then withdraw it just after that edge.
   task automatic applyStimulus(input logic [31:0] va, input logic [31:0] vb,
                                input logic vop);
      @(negedge clk);
      a                = va;
      b                = vb;
      operation_select = vop;
      in_valid         = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Check every registered field against a table record.
   task automatic checkVector(input int idx, input vec_t v);
      string p;
      p = $sformatf("v%0d.", idx);
      checkOutput({p, "out_valid"}, 32'(out_valid),       32'd1);
      checkOutput({p, "sign_l"},    32'(out_sign_l),      32'(v.sign_l));
      checkOutput({p, "sign_s"},    32'(out_sign_s),      32'(v.sign_s));
      checkOutput({p, "exp_l"},     32'(out_exp_l),       32'(v.exp_l));
      checkOutput({p, "mant_l"},    32'(out_mant_l),      32'(v.mant_l));
      checkOutput({p, "mant_s"},    32'(out_mant_s),      32'(v.mant_s));
      checkOutput({p, "shift"},     32'(out_shift),       32'(v.shift));
      checkOutput({p, "eff_sub"},   32'(out_eff_sub),     32'(v.eff_sub));
      checkOutput({p, "a_greater"}, 32'(out_a_greater),   32'(v.a_greater));
      checkOutput({p, "special"},   32'(out_special),     32'(v.special));
      checkOutput({p, "res"},       out_special_res,      v.res);
      checkOutput({p, "invalid"},   32'(out_invalid),     32'(v.invalid));
   endtask

   initial begin
      //             a             b             op sl ss exp   mant_l        mant_s        sh     es ag sp res           inv
      vecs[0]  = '{32'h3F800000, 32'h3F800000, 0, 0, 0, 8'd127, 24'h800000, 24'h800000, 5'd0,  0, 1, 0, 32'h00000000, 0};
      vecs[1]  = '{32'h40400000, 32'h3F800000, 1, 0, 1, 8'd128, 24'hC00000, 24'h800000, 5'd1,  1, 1, 0, 32'h00000000, 0};
      vecs[2]  = '{32'h3F800000, 32'h2B800000, 0, 0, 0, 8'd127, 24'h800000, 24'h800000, 5'd26, 0, 1, 0, 32'h00000000, 0};
      vecs[3]  = '{32'h2B800000, 32'h3F800000, 0, 0, 0, 8'd127, 24'h800000, 24'h800000, 5'd26, 0, 0, 0, 32'h00000000, 0};
      vecs[4]  = '{32'h7F800000, 32'hFF800000, 0, 0, 1, 8'd255, 24'h800000, 24'h800000, 5'd0,  1, 1, 1, 32'h7FC00000, 1};
      vecs[5]  = '{32'h7F800000, 32'h40000000, 1, 0, 1, 8'd255, 24'h800000, 24'h800000, 5'd26, 1, 1, 1, 32'h7F800000, 0};
      vecs[6]  = '{32'h7FC00000, 32'h3F800000, 0, 0, 0, 8'd255, 24'hC00000, 24'h800000, 5'd26, 0, 1, 1, 32'h7FC00000, 0};
      vecs[7]  = '{32'h3F800000, 32'h7F800001, 0, 0, 0, 8'd255, 24'h800001, 24'h800000, 5'd26, 0, 0, 1, 32'h7FC00000, 1};
      vecs[8]  = '{32'h00000000, 32'h00000001, 0, 0, 0, 8'd1,   24'h000001, 24'h000000, 5'd0,  0, 0, 0, 32'h00000000, 0};
      vecs[9]  = '{32'h3F800000, 32'h7F800000, 1, 1, 0, 8'd255, 24'h800000, 24'h800000, 5'd26, 1, 0, 1, 32'hFF800000, 0};
      vecs[10] = '{32'h3F800000, 32'h3F800000, 1, 0, 1, 8'd127, 24'h800000, 24'h800000, 5'd0,  1, 1, 0, 32'h00000000, 0};
      vecs[11] = '{32'h00800000, 32'h00400000, 0, 0, 0, 8'd1,   24'h800000, 24'h400000, 5'd0,  0, 1, 0, 32'h00000000, 0};
      vecs[12] = '{32'h3F800000, 32'h32800000, 0, 0, 0, 8'd127, 24'h800000, 24'h800000, 5'd26, 0, 1, 0, 32'h00000000, 0};
      vecs[13] = '{32'h3F800000, 32'h33000000, 0, 0, 0, 8'd127, 24'h800000, 24'h800000, 5'd25, 0, 1, 0, 32'h00000000, 0};
      vecs[14] = '{32'hBF800000, 32'h40000000, 0, 0, 1, 8'd128, 24'h800000, 24'h800000, 5'd1,  1, 0, 0, 32'h00000000, 0};
      vecs[15] = '{32'hFF800000, 32'hFF800000, 0, 1, 1, 8'd255, 24'h800000, 24'h800000, 5'd0,  0, 1, 1, 32'hFF800000, 0};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst.out_valid", 32'(out_valid),  32'd0);
      checkOutput("rst.in_ready",  32'(in_ready),   32'd1);
      checkOutput("rst.exp_l",     32'(out_exp_l),  32'd0);
      checkOutput("rst.mant_l",    32'(out_mant_l), 32'd0);
      checkOutput("rst.res",       out_special_res, 32'd0);

      // Table vectors with the output always accepted
      out_ready = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op);
         checkVector(i, vecs[i]);
      end
      @(posedge clk);
      #1;
      checkOutput("drain.out_valid", 32'(out_valid), 32'd0);

      // Backpressure: X = 3.0-1.0 held while Y = 1.0+1.0 waits upstream
      @(negedge clk);
      out_ready        = 1'b0;
      a                = 32'h40400000;
      b                = 32'h3F800000;
      operation_select = 1'b1;
      in_valid         = 1'b1;
      @(posedge clk);
      #1;
      a                = 32'h3F800000;
      b                = 32'h3F800000;
      operation_select = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkOutput($sformatf("bp%0d.out_valid", c), 32'(out_valid),  32'd1);
         checkOutput($sformatf("bp%0d.in_ready", c),  32'(in_ready),   32'd0);
         checkOutput($sformatf("bp%0d.exp_l", c),     32'(out_exp_l),  32'd128);
         checkOutput($sformatf("bp%0d.mant_l", c),    32'(out_mant_l), 32'hC00000);
         checkOutput($sformatf("bp%0d.shift", c),     32'(out_shift),  32'd1);
         checkOutput($sformatf("bp%0d.sign_s", c),    32'(out_sign_s), 32'd1);
      end
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checkOutput("bp.release_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp.y_valid",   32'(out_valid),   32'd1);
      checkOutput("bp.y_exp_l",   32'(out_exp_l),   32'd127);
      checkOutput("bp.y_mant_l",  32'(out_mant_l),  32'h800000);
      checkOutput("bp.y_shift",   32'(out_shift),   32'd0);
      checkOutput("bp.y_eff_sub", 32'(out_eff_sub), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("bp.drained", 32'(out_valid), 32'd0);

      // Reset while a set is held under backpressure
      @(negedge clk);
      out_ready = 1'b0;
      applyStimulus(32'h40400000, 32'h3F800000, 1'b1);
      checkOutput("rh.held_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rh.out_valid", 32'(out_valid),  32'd0);
      checkOutput("rh.in_ready",  32'(in_ready),   32'd1);
      checkOutput("rh.exp_l",     32'(out_exp_l),  32'd0);
      checkOutput("rh.mant_l",    32'(out_mant_l), 32'd0);
      checkOutput("rh.shift",     32'(out_shift),  32'd0);
      checkOutput("rh.eff_sub",   32'(out_eff_sub), 32'd0);
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("rh.never%0d", c), 32'(out_valid), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case the sequences above ever stall.
   initial begin
      #50000;
      $display("[TB] FAIL timeout: got no finish expected finish by t=50000");
      $fatal(1, "[TB] timeout");
   end

endmodule
